// File: rtl/imm_gen_stage_pkg.sv
// Shared CPU definitions for the immediate-generation stage:
// immediate format encodings, field widths and skid-buffer states.
package imm_gen_stage_pkg;

    localparam int unsigned INST_W     = 32;
    localparam int unsigned IMM_TYPE_W = 3;

    localparam logic [IMM_TYPE_W-1:0] IMM_I     = 3'd0;
    localparam logic [IMM_TYPE_W-1:0] IMM_NONE  = 3'd1;
    localparam logic [IMM_TYPE_W-1:0] IMM_S     = 3'd2;
    localparam logic [IMM_TYPE_W-1:0] IMM_B     = 3'd3;
    localparam logic [IMM_TYPE_W-1:0] IMM_U     = 3'd4;
    localparam logic [IMM_TYPE_W-1:0] IMM_J     = 3'd5;
    localparam logic [IMM_TYPE_W-1:0] IMM_ZIMM  = 3'd6;
    localparam logic [IMM_TYPE_W-1:0] IMM_SHAMT = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_decode.sv
// Combinational immediate decoder: assembles the selected format from the
// instruction word and extends it to XLEN.
module imm_decode
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0]     inst,
    input  logic [IMM_TYPE_W-1:0] imm_type,
    output logic [XLEN-1:0]       imm
);

    logic [31:0] imm32;
    logic        sext;

    // Opcode bits never contribute to any immediate.
    wire unused_opcode = &{1'b0, inst[6:0], 1'b0};

    // Build a 32-bit form first; sign-extending formats all carry their sign in bit 31.
    always_comb begin
        imm32 = '0;
        sext  = 1'b1;
        case (imm_type)
            IMM_I:     imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:     imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:     imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:     imm32 = {inst[31:12], 12'b0};
            IMM_J:     imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_ZIMM: begin
                imm32 = {27'b0, inst[19:15]};
                sext  = 1'b0;
            end
            IMM_SHAMT: begin
                imm32 = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
                sext  = 1'b0;
            end
            default: begin
                imm32 = '0;
                sext  = 1'b0;
            end
        endcase
        imm = sext ? XLEN'($signed(imm32)) : XLEN'(imm32);
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Immediate generation stage: decodes the immediate, forms pc+imm and
// queues results in a two-entry skid buffer with registered handshakes.
module imm_gen_stage
    import imm_gen_stage_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_W-1:0]     in_inst,
    input  logic [IMM_TYPE_W-1:0] in_immType,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [XLEN-1:0]       out_target,
    output logic [TAG_W-1:0]      out_tag
);

    logic [XLEN-1:0]  dec_imm;
    logic [XLEN-1:0]  dec_target;

    logic [XLEN-1:0]  skid_imm;
    logic [XLEN-1:0]  skid_target;
    logic [TAG_W-1:0] skid_tag;

    skid_state_e state;
    skid_state_e state_next;
    logic        accept;
    logic        pop;
    logic        load_head_in;
    logic        load_head_skid;
    logic        load_skid;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .inst     (in_inst),
        .imm_type (in_immType),
        .imm      (dec_imm)
    );

    assign dec_target = in_pc + dec_imm;

    // Next-state and datapath steering; flush overrides everything.
    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        accept         = in_valid && in_ready && !flush;
        pop            = out_valid && out_ready;
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next   = ST_ONE;
                        load_head_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        load_head_in = 1'b1;
                    end else if (accept) begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end else if (pop) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_next     = ST_ONE;
                        load_head_skid = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    // State register; handshake outputs are registered copies of the state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next != ST_FULL);
            out_valid <= (state_next != ST_EMPTY);
        end
    end

    // Head entry drives the outputs directly; the skid slot holds the second entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_imm     <= '0;
            out_target  <= '0;
            out_tag     <= '0;
            skid_imm    <= '0;
            skid_target <= '0;
            skid_tag    <= '0;
        end else begin
            if (load_head_in) begin
                out_imm    <= dec_imm;
                out_target <= dec_target;
                out_tag    <= in_tag;
            end else if (load_head_skid) begin
                out_imm    <= skid_imm;
                out_target <= skid_target;
                out_tag    <= skid_tag;
            end
            if (load_skid) begin
                skid_imm    <= dec_imm;
                skid_target <= dec_target;
                skid_tag    <= in_tag;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and
// are checked against a queue-based reference model.
module tb_imm_gen_stage;

    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [2:0]       in_imm_type;
    logic [31:0]      in_pc32;
    logic [63:0]      in_pc64;
    logic [TAG_W-1:0] in_tag;
    logic             out_ready;

    logic             in_ready32, in_ready64;
    logic             out_valid32, out_valid64;
    logic [31:0]      out_imm32, out_target32;
    logic [63:0]      out_imm64, out_target64;
    logic [TAG_W-1:0] out_tag32, out_tag64;

    imm_gen_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready32),
        .in_inst    (in_inst),
        .in_immType (in_imm_type),
        .in_pc      (in_pc32),
        .in_tag     (in_tag),
        .out_valid  (out_valid32),
        .out_ready  (out_ready),
        .out_imm    (out_imm32),
        .out_target (out_target32),
        .out_tag    (out_tag32)
    );

    imm_gen_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready64),
        .in_inst    (in_inst),
        .in_immType (in_imm_type),
        .in_pc      (in_pc64),
        .in_tag     (in_tag),
        .out_valid  (out_valid64),
        .out_ready  (out_ready),
        .out_imm    (out_imm64),
        .out_target (out_target64),
        .out_tag    (out_tag64)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0]      imm32;
        logic [63:0]      tgt32;
        logic [63:0]      imm64;
        logic [63:0]      tgt64;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t mq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Immediate value as a signed integer, then truncated to the datapath width.
    function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] ty,
                                            input int xlen);
        longint      v;
        logic [11:0] s;
        logic [12:0] b;
        logic [20:0] j;
        case (ty)
            3'd0: v = longint'($signed(inst[31:20]));
            3'd2: begin
                s = {inst[31:25], inst[11:7]};
                v = longint'($signed(s));
            end
            3'd3: begin
                b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                v = longint'($signed(b));
            end
            3'd4: v = longint'($signed(inst[31:12])) * 4096;
            3'd5: begin
                j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                v = longint'($signed(j));
            end
            3'd6: v = longint'(inst[19:15]);
            3'd7: v = (xlen == 64) ? longint'(inst[25:20]) : longint'(inst[24:20]);
            default: v = 0;
        endcase
        if (xlen == 64) return 64'(v);
        return 64'(v) & 64'hFFFF_FFFF;
    endfunction

    task automatic compare_all();
        logic exp_v;
        logic exp_r;
        exp_v = (mq.size() != 0);
        exp_r = (mq.size() < 2);
        chk("valid32", 64'(out_valid32), 64'(exp_v));
        chk("valid64", 64'(out_valid64), 64'(exp_v));
        chk("ready32", 64'(in_ready32), 64'(exp_r));
        chk("ready64", 64'(in_ready64), 64'(exp_r));
        if (mq.size() != 0) begin
            chk("imm32", 64'(out_imm32), mq[0].imm32);
            chk("tgt32", 64'(out_target32), mq[0].tgt32);
            chk("tag32", 64'(out_tag32), 64'(mq[0].tag));
            chk("imm64", out_imm64, mq[0].imm64);
            chk("tgt64", out_target64, mq[0].tgt64);
            chk("tag64", 64'(out_tag64), 64'(mq[0].tag));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid32"}, 64'(out_valid32), 64'd0);
        chk({tag, "_valid64"}, 64'(out_valid64), 64'd0);
        chk({tag, "_ready32"}, 64'(in_ready32), 64'd1);
        chk({tag, "_ready64"}, 64'(in_ready64), 64'd1);
        chk({tag, "_imm32"}, 64'(out_imm32), 64'd0);
        chk({tag, "_tgt32"}, 64'(out_target32), 64'd0);
        chk({tag, "_tag32"}, 64'(out_tag32), 64'd0);
        chk({tag, "_imm64"}, out_imm64, 64'd0);
        chk({tag, "_tgt64"}, out_target64, 64'd0);
        chk({tag, "_tag64"}, 64'(out_tag64), 64'd0);
    endtask

    // One clock: drive inputs, advance the model, sample just after the edge.
    task automatic step(input logic v, input logic [31:0] inst, input logic [2:0] ty,
                        input logic [63:0] pc, input logic [TAG_W-1:0] tg,
                        input logic ordy, input logic fl);
        exp_t e;
        logic acc;
        logic pop;
        in_valid    = v;
        in_inst     = inst;
        in_imm_type = ty;
        in_pc64     = pc;
        in_pc32     = pc[31:0];
        in_tag      = tg;
        out_ready   = ordy;
        flush       = fl;
        e.imm32 = ref_imm(inst, ty, 32);
        e.imm64 = ref_imm(inst, ty, 64);
        e.tgt32 = (pc + e.imm32) & 64'hFFFF_FFFF;
        e.tgt64 = pc + e.imm64;
        e.tag   = tg;
        acc = v && (mq.size() < 2) && !fl;
        pop = (mq.size() != 0) && ordy;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_inst     = '0;
        in_imm_type = '0;
        in_pc32     = '0;
        in_pc64     = '0;
        in_tag      = '0;
        out_ready   = 1'b0;
        #12;
        check_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // I-type all ones, visible one cycle after accept
        step(1'b1, 32'hFFF0_0093, 3'd0, 64'h0, 4'd5, 1'b1, 1'b0);
        chk("i_imm32", 64'(out_imm32), 64'hFFFF_FFFF);
        chk("i_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);
        step(1'b0, 32'h0, 3'd0, 64'h0, 4'd0, 1'b1, 1'b0);

        // Negative branch offset
        step(1'b1, 32'hFE00_0EE3, 3'd3, 64'h100, 4'd6, 1'b1, 1'b0);
        chk("b_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
        chk("b_tgt32", 64'(out_target32), 64'h0000_00FC);

        // Jump target wraps past the top of the 32-bit space
        step(1'b1, 32'h0080_00EF, 3'd5, 64'hFFFF_FFFC, 4'd7, 1'b1, 1'b0);
        chk("j_imm32", 64'(out_imm32), 64'h8);
        chk("j_tgt32", 64'(out_target32), 64'h4);

        // 64-bit U sign extension and 6-bit shamt
        step(1'b1, 32'h8000_00B7, 3'd4, 64'h0, 4'd8, 1'b1, 1'b0);
        chk("u_imm64", out_imm64, 64'hFFFF_FFFF_8000_0000);
        step(1'b1, 32'h03F0_0013, 3'd7, 64'h0, 4'd9, 1'b1, 1'b0);
        chk("sh_imm64", out_imm64, 64'h3F);
        chk("sh_imm32", 64'(out_imm32), 64'h1F);
        step(1'b0, 32'h0, 3'd0, 64'h0, 4'd0, 1'b1, 1'b0);

        // Backpressure: fill, stall, then drain in order
        step(1'b1, 32'h0010_0093, 3'd0, 64'h10, 4'd1, 1'b0, 1'b0);
        chk("bp_ready_1", 64'(in_ready32), 64'd1);
        step(1'b1, 32'h0020_0093, 3'd0, 64'h20, 4'd2, 1'b0, 1'b0);
        chk("bp_ready_2", 64'(in_ready32), 64'd0);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h30, 4'd3, 1'b0, 1'b0);
        chk("bp_head_1", 64'(out_tag32), 64'd1);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h30, 4'd3, 1'b1, 1'b0);
        chk("bp_head_2", 64'(out_tag32), 64'd2);
        chk("bp_ready_back", 64'(in_ready32), 64'd1);
        step(1'b1, 32'h0030_0093, 3'd0, 64'h30, 4'd3, 1'b1, 1'b0);
        chk("bp_head_3", 64'(out_tag32), 64'd3);
        step(1'b0, 32'h0, 3'd0, 64'h0, 4'd0, 1'b1, 1'b0);
        chk("bp_drained", 64'(out_valid32), 64'd0);

        // Flush while full and offered a new entry
        step(1'b1, 32'h1234_5013, 3'd2, 64'h40, 4'd4, 1'b0, 1'b0);
        step(1'b1, 32'h8765_4013, 3'd5, 64'h50, 4'd5, 1'b0, 1'b0);
        step(1'b1, 32'hABCD_E013, 3'd4, 64'h60, 4'd6, 1'b0, 1'b1);
        chk("flush_valid", 64'(out_valid32), 64'd0);
        chk("flush_ready", 64'(in_ready32), 64'd1);

        // Asynchronous reset pulse mid-stream
        step(1'b1, 32'hFFFF_F013, 3'd0, 64'h70, 4'd7, 1'b0, 1'b0);
        step(1'b1, 32'h7FFF_F013, 3'd4, 64'h80, 4'd8, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        mq.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();
        chk("postrst_valid", 64'(out_valid32), 64'd0);

        // Randomised traffic with bursty backpressure and occasional flush
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                 {$urandom, $urandom}, TAG_W'($urandom), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 31) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
